// File: rtl/quote_order_tx.sv
// Quote-to-limit-order encoder: turns bid/ask pairs into 3-word order messages on a
// valid/ready stream, suppressing unchanged sides and buffering one quote while busy.
module quote_order_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ORDER_QTY  = 100,
  parameter int unsigned ID_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_buy_price,
  input  logic [DATA_WIDTH-1:0] i_ask_price,
  input  logic                  i_data_valid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_tx_last,
  input  logic                  i_tx_ready,
  output logic [15:0]           o_reject_count,
  output logic [15:0]           o_overwrite_count
);

  typedef enum logic [2:0] {
    StIdle, StBuyHdr, StBuyPrice, StBuyQty, StAskHdr, StAskPrice, StAskQty
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] act_buy_q, act_buy_d, act_ask_q, act_ask_d;
  logic                  send_ask_q, send_ask_d;
  logic [DATA_WIDTH-1:0] last_buy_q, last_buy_d, last_ask_q, last_ask_d;
  logic                  seen_q, seen_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_buy_q, pend_buy_d, pend_ask_q, pend_ask_d;
  logic [ID_WIDTH-1:0]   order_id_q, order_id_d;
  logic [15:0]           reject_q, reject_d, overwrite_q, overwrite_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;

  logic        hs, not_crossed, accept, eom;
  logic        p_sb, p_sa, n_sb, n_sa;
  logic [15:0] id16;

  function automatic state_e first_state(input logic sb, input logic sa);
    if (sb) return StBuyHdr;
    if (sa) return StAskHdr;
    return StIdle;
  endfunction

  always_comb begin
    state_d      = state_q;
    act_buy_d    = act_buy_q;
    act_ask_d    = act_ask_q;
    send_ask_d   = send_ask_q;
    last_buy_d   = last_buy_q;
    last_ask_d   = last_ask_q;
    seen_d       = seen_q;
    pend_valid_d = pend_valid_q;
    pend_buy_d   = pend_buy_q;
    pend_ask_d   = pend_ask_q;
    order_id_d   = order_id_q;
    reject_d     = reject_q;
    overwrite_d  = overwrite_q;
    p_sb         = 1'b0;
    p_sa         = 1'b0;
    n_sb         = 1'b0;
    n_sa         = 1'b0;
    eom          = 1'b0;
    hs           = tx_valid_q && i_tx_ready;
    not_crossed  = i_buy_price < i_ask_price;
    accept       = i_data_valid && not_crossed;

    if (i_data_valid && !not_crossed && reject_q != 16'hFFFF) begin
      reject_d = reject_q + 16'd1;
    end

    case (state_q)
      StIdle:     ;
      StBuyHdr:   if (hs) state_d = StBuyPrice;
      StBuyPrice: if (hs) state_d = StBuyQty;
      StBuyQty: begin
        if (hs) begin
          order_id_d = order_id_q + ID_WIDTH'(1);
          if (send_ask_q) state_d = StAskHdr;
          else            eom     = 1'b1;
        end
      end
      StAskHdr:   if (hs) state_d = StAskPrice;
      StAskPrice: if (hs) state_d = StAskQty;
      StAskQty: begin
        if (hs) begin
          order_id_d = order_id_q + ID_WIDTH'(1);
          eom        = 1'b1;
        end
      end
      default:    state_d = StIdle;
    endcase

    if (state_q == StIdle || eom) begin
      state_d = StIdle;
      // Pending quote goes first; a new quote loads directly only if pending sent nothing.
      if (pend_valid_q) begin
        pend_valid_d = 1'b0;
        p_sb         = !seen_q || pend_buy_q != last_buy_q;
        p_sa         = !seen_q || pend_ask_q != last_ask_q;
        act_buy_d    = pend_buy_q;
        act_ask_d    = pend_ask_q;
        last_buy_d   = pend_buy_q;
        last_ask_d   = pend_ask_q;
        seen_d       = 1'b1;
        send_ask_d   = p_sa;
        state_d      = first_state(p_sb, p_sa);
      end
      if (accept) begin
        if (state_d == StIdle) begin
          n_sb       = !seen_d || i_buy_price != last_buy_d;
          n_sa       = !seen_d || i_ask_price != last_ask_d;
          act_buy_d  = i_buy_price;
          act_ask_d  = i_ask_price;
          last_buy_d = i_buy_price;
          last_ask_d = i_ask_price;
          seen_d     = 1'b1;
          send_ask_d = n_sa;
          state_d    = first_state(n_sb, n_sa);
        end else begin
          pend_valid_d = 1'b1;
          pend_buy_d   = i_buy_price;
          pend_ask_d   = i_ask_price;
        end
      end
    end else if (accept) begin
      if (pend_valid_q && overwrite_q != 16'hFFFF) overwrite_d = overwrite_q + 16'd1;
      pend_valid_d = 1'b1;
      pend_buy_d   = i_buy_price;
      pend_ask_d   = i_ask_price;
    end
  end

  // Output words are computed from next-state so the ports come straight from flops.
  always_comb begin
    id16       = 16'(order_id_d);
    tx_valid_d = state_d != StIdle;
    tx_last_d  = (state_d == StBuyQty) || (state_d == StAskQty);
    tx_data_d  = '0;
    case (state_d)
      StBuyHdr:            tx_data_d = DATA_WIDTH'({8'hA5, 8'h01, id16});
      StBuyPrice:          tx_data_d = act_buy_d;
      StAskHdr:            tx_data_d = DATA_WIDTH'({8'hA5, 8'h02, id16});
      StAskPrice:          tx_data_d = act_ask_d;
      StBuyQty, StAskQty:  tx_data_d = DATA_WIDTH'({16'h0, 16'(ORDER_QTY)});
      default:             tx_data_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      act_buy_q    <= '0;
      act_ask_q    <= '0;
      send_ask_q   <= 1'b0;
      last_buy_q   <= '0;
      last_ask_q   <= '0;
      seen_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_buy_q   <= '0;
      pend_ask_q   <= '0;
      order_id_q   <= '0;
      reject_q     <= '0;
      overwrite_q  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_buy_q    <= act_buy_d;
      act_ask_q    <= act_ask_d;
      send_ask_q   <= send_ask_d;
      last_buy_q   <= last_buy_d;
      last_ask_q   <= last_ask_d;
      seen_q       <= seen_d;
      pend_valid_q <= pend_valid_d;
      pend_buy_q   <= pend_buy_d;
      pend_ask_q   <= pend_ask_d;
      order_id_q   <= order_id_d;
      reject_q     <= reject_d;
      overwrite_q  <= overwrite_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
    end
  end

  assign o_tx_data         = tx_data_q;
  assign o_tx_valid        = tx_valid_q;
  assign o_tx_last         = tx_last_q;
  assign o_reject_count    = reject_q;
  assign o_overwrite_count = overwrite_q;

endmodule

// File: tb/tb_quote_order_tx.sv
// Bench for quote_order_tx: a word-queue reference model plus directed and random scenarios.
module tb_quote_order_tx;

  logic        clk = 1'b0;
  logic        rst_n, dv, ready;
  logic [31:0] buy, ask;
  logic [31:0] tx_data;
  logic        tx_valid, tx_last;
  logic [15:0] rej, ovw;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  quote_order_tx #(
    .DATA_WIDTH(32),
    .ORDER_QTY (100),
    .ID_WIDTH  (16)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_buy_price      (buy),
    .i_ask_price      (ask),
    .i_data_valid     (dv),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .o_tx_last        (tx_last),
    .i_tx_ready       (ready),
    .o_reject_count   (rej),
    .o_overwrite_count(ovw)
  );

  // Reference model: outstanding words are a FIFO; the head is what should be on the bus.
  logic [31:0] m_data[$];
  logic        m_last[$];
  logic        m_pend_v, m_seen;
  logic [31:0] m_pend_b, m_pend_a, m_last_b, m_last_a;
  logic [15:0] m_id;
  int          m_rej, m_ovw;
  bit          m_busy0, m_eom, m_acc;

  function automatic void push_order(input logic [7:0] side, input logic [31:0] price);
    m_data.push_back({8'hA5, side, m_id}); m_last.push_back(1'b0);
    m_data.push_back(price);               m_last.push_back(1'b0);
    m_data.push_back(32'd100);             m_last.push_back(1'b1);
    m_id = m_id + 16'd1;
  endfunction

  function automatic void m_load(input logic [31:0] b, input logic [31:0] a);
    bit sb, sa;
    sb = !m_seen || b != m_last_b;
    sa = !m_seen || a != m_last_a;
    m_last_b = b;
    m_last_a = a;
    m_seen   = 1'b1;
    if (sb) push_order(8'h01, b);
    if (sa) push_order(8'h02, a);
  endfunction

  function automatic logic exp_valid();
    return m_data.size() != 0;
  endfunction
  function automatic logic [31:0] exp_data();
    return (m_data.size() != 0) ? m_data[0] : 32'h0;
  endfunction
  function automatic logic exp_last();
    return (m_last.size() != 0) ? m_last[0] : 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_data.delete();
      m_last.delete();
      m_pend_v = 1'b0; m_seen = 1'b0;
      m_pend_b = '0; m_pend_a = '0; m_last_b = '0; m_last_a = '0;
      m_id = '0; m_rej = 0; m_ovw = 0;
    end else begin
      m_busy0 = m_data.size() != 0;
      m_eom   = 1'b0;
      m_acc   = dv && (buy < ask);
      if (dv && !(buy < ask) && m_rej < 65535) m_rej++;
      if (m_busy0 && ready) begin
        void'(m_data.pop_front());
        void'(m_last.pop_front());
        m_eom = m_data.size() == 0;
      end
      if (!m_busy0 || m_eom) begin
        if (m_pend_v) begin
          m_pend_v = 1'b0;
          m_load(m_pend_b, m_pend_a);
        end
        if (m_acc) begin
          if (m_data.size() == 0) m_load(buy, ask);
          else begin
            m_pend_v = 1'b1; m_pend_b = buy; m_pend_a = ask;
          end
        end
      end else if (m_acc) begin
        if (m_pend_v && m_ovw < 65535) m_ovw++;
        m_pend_v = 1'b1; m_pend_b = buy; m_pend_a = ask;
      end
    end
  end

  task automatic tick(input logic r_n, input logic v, input logic [31:0] b,
                      input logic [31:0] a, input logic rdy);
    @(negedge clk);
    rst_n = r_n; dv = v; buy = b; ask = a; ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 32'd1, 32'd2, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_tests++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", tx_last); end
    n_tests++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tx_data); end
    n_tests++; if (rej !== 16'h0) begin n_fail++; $display("FAIL reset_rej: got %0d want 0", rej); end
    n_tests++; if (ovw !== 16'h0) begin n_fail++; $display("FAIL reset_ovw: got %0d want 0", ovw); end
  endtask

  task automatic test_basic();
    logic [31:0] got[$];
    logic [31:0] want[6];
    want = '{32'hA5010000, 32'h000003E8, 32'h00000064, 32'hA5020001, 32'h000003F2, 32'h00000064};
    tick(1'b1, 1'b1, 32'd1000, 32'd1010, 1'b1);
    n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid=%b want 1", tx_valid); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({tx_valid, tx_last, tx_data} !== {exp_valid(), exp_last(), exp_data()}) begin
        n_fail++;
        $display("FAIL basic_cyc%0d: got v=%b l=%b d=%h want v=%b l=%b d=%h", i, tx_valid,
                 tx_last, tx_data, exp_valid(), exp_last(), exp_data());
      end
      if (tx_valid) got.push_back(tx_data);
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_suppress();
    logic [31:0] got[$];
    for (int q = 0; q < 2; q++) begin
      got.delete();
      tick(1'b1, 1'b1, 32'd1000, 32'd1012, 1'b1);
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if ({tx_valid, tx_last, tx_data} !== {exp_valid(), exp_last(), exp_data()}) begin
          n_fail++;
          $display("FAIL suppress%0d_cyc%0d: got v=%b d=%h want v=%b d=%h", q, i, tx_valid,
                   tx_data, exp_valid(), exp_data());
        end
        if (tx_valid) got.push_back(tx_data);
        tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      end
      n_tests++;
      if (got.size() != ((q == 0) ? 3 : 0)) begin
        n_fail++; $display("FAIL suppress%0d_count: got %0d want %0d", q, got.size(), (q == 0) ? 3 : 0);
      end
      if (q == 0 && got.size() > 0) begin
        n_tests++;
        if (got[0] !== 32'hA5020002) begin n_fail++; $display("FAIL suppress_hdr: got %h want a5020002", got[0]); end
      end
    end
  endtask

  task automatic test_reject();
    tick(1'b1, 1'b1, 32'd1010, 32'd1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reject_valid%0d: got %b want 0", i, tx_valid); end
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_tests++; if (rej !== 16'd1) begin n_fail++; $display("FAIL reject_count: got %0d want 1", rej); end
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    logic [31:0] want[12];
    int bubbles;
    want = '{32'hA5010000, 32'd1000, 32'd100, 32'hA5020001, 32'd1010, 32'd100,
             32'hA5010002, 32'd1002, 32'd100, 32'hA5020003, 32'd1012, 32'd100};
    bubbles = 0;
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 32'd1000, 32'd1010, 1'b0);
    tick(1'b1, 1'b1, 32'd1001, 32'd1011, 1'b0);
    tick(1'b1, 1'b1, 32'd1002, 32'd1012, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA5010000 || tx_last !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h l=%b want v=1 d=a5010000 l=0", i, tx_valid, tx_data, tx_last);
      end
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    n_tests++; if (ovw !== 16'd1) begin n_fail++; $display("FAIL stall_ovw: got %0d want 1", ovw); end
    for (int i = 0; i < 14; i++) begin
      n_tests++;
      if ({tx_valid, tx_last, tx_data} !== {exp_valid(), exp_last(), exp_data()}) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: got v=%b l=%b d=%h want v=%b l=%b d=%h", i, tx_valid,
                 tx_last, tx_data, exp_valid(), exp_last(), exp_data());
      end
      if (i < 12 && !tx_valid) bubbles++;
      if (tx_valid) got.push_back(tx_data);
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_tests++; if (bubbles != 0) begin n_fail++; $display("FAIL stall_bubbles: got %0d want 0", bubbles); end
    n_tests++; if (got.size() != 12) begin n_fail++; $display("FAIL stall_count: got %0d want 12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_id_wrap();
    logic [31:0] got[$];
    @(negedge clk);
    dv = 1'b0;
    force dut.order_id_q = 16'hFFFF;
    @(negedge clk);
    release dut.order_id_q;
    m_id = 16'hFFFF;
    tick(1'b1, 1'b1, 32'd2000, 32'd2010, 1'b1);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if ({tx_valid, tx_last, tx_data} !== {exp_valid(), exp_last(), exp_data()}) begin
        n_fail++;
        $display("FAIL wrap_cyc%0d: got v=%b d=%h want v=%b d=%h", i, tx_valid, tx_data,
                 exp_valid(), exp_data());
      end
      if (tx_valid) got.push_back(tx_data);
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_tests++;
    if (got.size() != 6 || got[0] !== 32'hA501FFFF || got[3] !== 32'hA5020000) begin
      n_fail++;
      $display("FAIL wrap_hdrs: got n=%0d h0=%h h1=%h want n=6 h0=a501ffff h1=a5020000",
               got.size(), (got.size() > 0) ? got[0] : 32'h0, (got.size() > 3) ? got[3] : 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got[$];
    tick(1'b1, 1'b1, 32'd5, 32'd5, 1'b1);
    tick(1'b1, 1'b1, 32'd3000, 32'd3010, 1'b1);
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    n_tests++;
    if (tx_data !== 32'd3000 || rej !== 16'd1) begin
      n_fail++; $display("FAIL midrst_pre: got d=%h rej=%0d want d=00000bb8 rej=1", tx_data, rej);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0 || rej !== 16'd0 || ovw !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b d=%h rej=%0d ovw=%0d want v=0 d=0 rej=0 ovw=0",
               tx_valid, tx_data, rej, ovw);
    end
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b1, 32'd3000, 32'd3010, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (tx_valid) got.push_back(tx_data);
      tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_tests++;
    if (got.size() != 6 || got[0] !== 32'hA5010000 || got[3] !== 32'hA5020001) begin
      n_fail++;
      $display("FAIL midrst_resend: got n=%0d h0=%h h1=%h want n=6 h0=a5010000 h1=a5020001",
               got.size(), (got.size() > 0) ? got[0] : 32'h0, (got.size() > 3) ? got[3] : 32'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(1'b1, ($urandom % 3) == 0, 32'd500 + ($urandom % 8), 32'd500 + ($urandom % 8),
           ($urandom % 4) != 0);
      n_tests++;
      if ({tx_valid, tx_last, tx_data} !== {exp_valid(), exp_last(), exp_data()} ||
          rej !== 16'(m_rej) || ovw !== 16'(m_ovw)) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got v=%b l=%b d=%h rej=%0d ovw=%0d want v=%b l=%b d=%h rej=%0d ovw=%0d",
                 i, tx_valid, tx_last, tx_data, rej, ovw, exp_valid(), exp_last(), exp_data(),
                 m_rej, m_ovw);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; dv = 1'b0; buy = '0; ask = '0; ready = 1'b1;
    test_reset();
    test_basic();
    test_suppress();
    test_reject();
    test_stall();
    test_id_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quote_order_tx.md
Name: quote_order_tx

Overview:
- Downstream consumer of the quote pricing stage.
- Takes each valid buy/ask price pair and encodes it into outbound limit-order messages.
- Streams the messages as 32-bit words over a valid/ready interface toward the exchange transmit path.
- Suppresses unchanged sides, rejects crossed quotes and holds one pending quote while busy.

Parameters:
- DATA_WIDTH, 32, price width and output word width.
- ORDER_QTY, 100, fixed quantity placed in every order (16 bits used).
- ID_WIDTH, 16, order-id counter width.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, synchronous active-low reset.
- i_buy_price, input, DATA_WIDTH, bid price from pricing stage.
- i_ask_price, input, DATA_WIDTH, ask price from pricing stage.
- i_data_valid, input, 1, one-cycle strobe; prices are valid this cycle. No backpressure is possible upstream.
- o_tx_data, output, DATA_WIDTH, message word.
- o_tx_valid, output, 1, word valid.
- o_tx_last, output, 1, final word of an order message.
- i_tx_ready, input, 1, downstream accepts the word.
- o_reject_count, output, 16, count of crossed quotes dropped; saturates at 0xFFFF.
- o_overwrite_count, output, 16, count of pending quotes overwritten; saturates.

Behaviour:
- Reset: i_rst_n low at a clock edge clears all of the following; takes priority over everything, including mid-message (message is aborted, not completed):
  - o_tx_valid = 0, o_tx_last = 0, o_tx_data = 0.
  - Both counters = 0.
  - Order id = 0.
  - Pending slot empty.
  - Last-sent prices = 0, with a `seen` flag = 0.
  - FSM = IDLE.
- Acceptance: a quote is accepted at any edge where i_data_valid = 1.
  - Crossed quote (buy >= ask): dropped, o_reject_count increments, no other effect.
- Message format: three words per order; o_tx_last = 1 only on QTY.
  - HDR = {8'hA5, side[7:0] (8'h01 buy, 8'h02 sell), order_id[15:0]}.
  - PRICE = price.
  - QTY = {16'h0, ORDER_QTY[15:0]}.
- Load into active registers:
  - send_buy = !seen || buy != last_buy.
  - send_ask = !seen || ask != last_ask.
  - Then last_buy/last_ask are updated to the loaded prices and seen = 1.
  - If neither side needs sending, nothing is emitted and the quote is consumed.
- FSM states: IDLE, BUY_HDR, BUY_PRICE, BUY_QTY, ASK_HDR, ASK_PRICE, ASK_QTY.
  - IDLE + accepted quote: load; next state BUY_HDR if send_buy, else ASK_HDR if send_ask, else stay IDLE.
  - Latency: accept at edge N puts the header on the output with o_tx_valid = 1 after edge N (visible in cycle N+1).
  - Each word state advances only on the handshake (o_tx_valid && i_tx_ready).
  - BUY_QTY handshake: go to ASK_HDR if send_ask, else end-of-message.
  - ASK_QTY handshake: end-of-message.
  - Order id increments on each QTY handshake and wraps from all-ones to 0.
- End-of-message:
  - Pending full: load pending (same suppression rules) and go straight to its first header with no idle bubble; pending becomes empty. If the pending quote suppresses both sides, go to IDLE.
  - Pending empty: go to IDLE, o_tx_valid = 0.
- Pending slot (busy = any non-IDLE state):
  - Quote accepted while busy is written to pending.
  - If pending is already full, it is overwritten (latest wins) and o_overwrite_count increments.
- Simultaneous quote and final handshake:
  - Pending empty: the new quote loads directly as the active quote.
  - Pending full: pending becomes active and the new quote occupies pending; no overwrite counted.
- Output stability: while o_tx_valid = 1 and i_tx_ready = 0, o_tx_data and o_tx_last hold constant.
- Output registering: outputs are registered; i_tx_ready does not combinationally drive o_tx_valid.

Test Plan:
- Reset, then buy=1000, ask=1010, ready held 1 → six words:
  - A5010000, 000003E8, 00000064 (last=1).
  - A5020001, 000003F2, 00000064 (last=1).
  - o_tx_valid first high one cycle after the strobe.
- Repeat buy=1000, ask=1012 → only the sell order, header A5020002; identical quote repeated → no output.
- Crossed quote buy=1010, ask=1010 → no output, o_reject_count=1.
- With ready=0, send three quotes (1000/1010, 1001/1011, 1002/1012) back-to-back:
  - o_overwrite_count=1.
  - Data held stable while stalled.
  - After releasing ready, the 1000/1010 then 1002/1012 messages follow with no bubble between them.
- Preload order id to 0xFFFF via 65535 orders (or force) → next id 0x0000.
- Assert i_rst_n=0 during BUY_PRICE → next cycle o_tx_valid=0 and counters 0; after reset, repeating the pre-reset quote emits both sides again (seen cleared).
